// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one RAM port between the instruction-fetch path and the data
// (load/store) path of the 5-stage pipeline. A registered FSM
// (IDLE -> DBUS/IBUS -> DONE -> IDLE) runs each access:
//   * IDLE picks a requester. Data normally wins.
//   * DBUS/IBUS drive the RAM strobes from latched copies of the request.
//     They wait out FREE/BUSY and retry ERROR responses up to MAX_RETRY times.
//   * DONE pulses ihit or dhit for exactly one cycle. The requester drops its
//     request at the edge that ends DONE. No arbitration happens in DONE, so a
//     stale request is never granted a second time.
//
// Optional feature (compile-time macro MEM_ARBITER_ARB_FAIR_EN):
//   Adds a starve counter. It counts data grants made while an instruction
//   fetch was waiting. When it reaches STARVE_LIMIT, the next IDLE grant goes
//   to the instruction path. Without the macro the arbiter uses strict data
//   priority and the counter does not exist.
//
// Parameters
//   WORD_W        data / address width
//   MAX_RETRY     ERROR responses tolerated per access before it is abandoned
//   STARVE_LIMIT  lost arbitrations before fetch is forced (fair build only)
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          instruction read request (held until ihit) + address
//   ihit, iload          one-cycle hit pulse + registered instruction word
//   dREN, dWEN           data read / write request (held until dhit)
//   daddr, dstore        data address + store data
//   dhit, dload          one-cycle hit pulse + registered load word
//   ramREN, ramWEN       RAM read / write strobes (registered)
//   ramaddr, ramstore    RAM address / write data (from internal latches)
//   ramload, ramstate    RAM read data / status (0 FREE,1 BUSY,2 ACCESS,3 ERROR)
//   mem_err              sticky: an access was abandoned after MAX_RETRY errors
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int MAX_RETRY    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction path
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  // data path
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  // RAM port
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // status
  output logic              mem_err
);

  // RAM status codes that change the FSM's course. FREE and BUSY both mean
  // "keep waiting", so the FSM does not decode them separately.
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  // The counter must hold the value MAX_RETRY itself, and it is kept at
  // least one bit wide so that MAX_RETRY = 0 still elaborates.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBUS = 2'd1,
    IBUS = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_reg;
  logic [RETRY_W-1:0]   retry_reg;
  logic [WORD_W-1:0]    addr_reg;
  logic [WORD_W-1:0]    store_reg;
  logic [WORD_W-1:0]    iload_reg;
  logic [WORD_W-1:0]    dload_reg;
  logic                 write_reg;    // latched op: 1 = data store
  logic                 ren_reg;
  logic                 wen_reg;
  logic                 ihit_reg;
  logic                 dhit_reg;
  logic                 mem_err_reg;

  logic                 data_req;
  logic                 force_ifetch;
  logic                 grant_d;
  logic                 grant_i;
  logic                 retry_left;

  assign data_req = dREN | dWEN;

`ifdef MEM_ARBITER_ARB_FAIR_EN
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0]  starve_reg;

  // Once the data path has won STARVE_LIMIT times in a row over a waiting
  // fetch, the fetch gets the port.
  assign force_ifetch = iREN && (starve_reg == STARVE_W'(STARVE_LIMIT));
`else
  assign force_ifetch = 1'b0;
`endif

  assign grant_d    = data_req && !force_ifetch;
  assign grant_i    = iREN && !grant_d;
  assign retry_left = (retry_reg < RETRY_W'(MAX_RETRY));

  // -------------------------------------------------------------------------
  // Single FSM process. Every output is a register, so reset clears the RAM
  // strobes, the hit pulses and mem_err without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      retry_reg   <= '0;
      addr_reg    <= '0;
      store_reg   <= '0;
      iload_reg   <= '0;
      dload_reg   <= '0;
      write_reg   <= 1'b0;
      ren_reg     <= 1'b0;
      wen_reg     <= 1'b0;
      ihit_reg    <= 1'b0;
      dhit_reg    <= 1'b0;
      mem_err_reg <= 1'b0;
`ifdef MEM_ARBITER_ARB_FAIR_EN
      starve_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          retry_reg <= '0;
          if (grant_d) begin
            // When dREN and dWEN are both high, the access is a write.
            state_reg <= DBUS;
            addr_reg  <= daddr;
            store_reg <= dstore;
            write_reg <= dWEN;
            ren_reg   <= ~dWEN;
            wen_reg   <= dWEN;
`ifdef MEM_ARBITER_ARB_FAIR_EN
            if (iREN && (starve_reg != STARVE_W'(STARVE_LIMIT))) begin
              starve_reg <= starve_reg + 1'b1;
            end
`endif
          end else if (grant_i) begin
            state_reg <= IBUS;
            addr_reg  <= iaddr;
            store_reg <= '0;
            write_reg <= 1'b0;
            ren_reg   <= 1'b1;
            wen_reg   <= 1'b0;
`ifdef MEM_ARBITER_ARB_FAIR_EN
            starve_reg <= '0;
`endif
          end
        end

        DBUS, IBUS: begin
          if (ramstate == RS_ACCESS) begin
            state_reg <= DONE;
            retry_reg <= '0;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            if (state_reg == DBUS) begin
              dhit_reg <= 1'b1;
              if (!write_reg) begin
                dload_reg <= ramload;
              end
            end else begin
              ihit_reg  <= 1'b1;
              iload_reg <= ramload;
            end
          end else if (ramstate == RS_ERROR) begin
            if (retry_left) begin
              // Keep the strobes up and let the RAM try again.
              retry_reg <= retry_reg + 1'b1;
            end else begin
              // The retries are used up. Abandon the access but still pulse
              // the hit so the pipeline is not stalled forever. The load
              // register keeps its old value.
              state_reg   <= DONE;
              retry_reg   <= '0;
              ren_reg     <= 1'b0;
              wen_reg     <= 1'b0;
              mem_err_reg <= 1'b1;
              if (state_reg == DBUS) begin
                dhit_reg <= 1'b1;
              end else begin
                ihit_reg <= 1'b1;
              end
            end
          end
          // FREE / BUSY: hold everything as it is.
        end

        DONE: begin
          ihit_reg  <= 1'b0;
          dhit_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ihit     = ihit_reg;
  assign iload    = iload_reg;
  assign dhit     = dhit_reg;
  assign dload    = dload_reg;
  assign ramREN   = ren_reg;
  assign ramWEN   = wen_reg;
  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;
  assign mem_err  = mem_err_reg;

endmodule
